// File: rtl/axis_xor_pkg.sv
// axis_xor_pkg: shared types and helpers for the AXI4-Stream XOR cipher.
// Mode encoding, per-lane keep mask and key-index width.
package axis_xor_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'd0,
    STATIC  = 2'd1,
    ROLLING = 2'd2
  } xor_mode_e;

  // Index width for a key table of n entries; never narrower than 1 bit.
  function automatic int key_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Expand one tkeep bit into the 8-bit mask of its byte lane.
  function automatic logic [7:0] keep_mask(input logic keep);
    return {8{keep}};
  endfunction

  // Map the raw mode field; the reserved code behaves as bypass.
  function automatic xor_mode_e decode_mode(input logic [1:0] m);
    xor_mode_e r;
    r = BYPASS;
    unique case (m)
      2'd1:    r = STATIC;
      2'd2:    r = ROLLING;
      default: r = BYPASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: output register plus one skid register.
// s_ready_o is registered and means "skid register empty".
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             rdy_q;
  logic             accept;
  logic             load;

  assign accept = s_valid_i & rdy_q;
  assign load   = ~out_vld_q | m_ready_i;

  // Next state: refill output from skid first, else from the input.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (load) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = s_data_i;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = s_data_i;
      skid_vld_d = 1'b1;
    end
  end

  // Register both stages; ready tracks the next skid occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign s_ready_o = rdy_q;
  assign m_data_o  = out_q;
  assign m_valid_o = out_vld_q;

endmodule

// File: rtl/axis_xor_v2.sv
// axis_xor_v2: AXI4-Stream XOR cipher with key table and stats.
// XOR happens before the skid buffer, so outputs are registered.
module axis_xor_v2
  import axis_xor_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [WIDTH-1:0]               slave_tdata,
  input  logic [WIDTH/8-1:0]             slave_tkeep,
  input  logic                           slave_tvalid,
  output logic                           slave_tready,
  input  logic                           slave_tlast,
  output logic [WIDTH-1:0]               master_tdata,
  output logic [WIDTH/8-1:0]             master_tkeep,
  output logic                           master_tvalid,
  input  logic                           master_tready,
  output logic                           master_tlast,
  input  logic [1:0]                     cfg_mode,
  input  logic                           key_wr_en,
  input  logic [key_idx_w(NUM_KEYS)-1:0] key_wr_addr,
  input  logic [WIDTH-1:0]               key_wr_data,
  output logic [CNT_W-1:0]               stat_beats,
  output logic [CNT_W-1:0]               stat_pkts
);

  localparam int KW = WIDTH / 8;
  localparam int IW = key_idx_w(NUM_KEYS);
  localparam int BW = WIDTH + KW + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_KEYS - 1);

  logic [WIDTH-1:0] key_q [NUM_KEYS];
  logic [IW-1:0]    idx_q, idx_d;
  xor_mode_e        mode_q, mode_d, mode_cur;
  logic             in_pkt_q, in_pkt_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] pkts_q, pkts_d;
  logic             accept;
  logic [WIDTH-1:0] key_sel;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] xdata;
  logic [BW-1:0]    s_bus, m_bus;

  assign accept = slave_tvalid & slave_tready;

  // First beat of a packet uses the live mode; later beats the latch.
  assign mode_cur = in_pkt_q ? mode_q : decode_mode(cfg_mode);

  // Key for the beat on the slave side, read before any write lands.
  always_comb begin
    key_sel = '0;
    unique case (1'b1)
      (mode_cur == STATIC):  key_sel = key_q[0];
      (mode_cur == ROLLING): key_sel = key_q[idx_q];
      default:               key_sel = '0;
    endcase
  end

  for (genvar b = 0; b < KW; b++) begin : g_mask
    assign mask[b*8 +: 8] = keep_mask(slave_tkeep[b]);
  end

  assign xdata = (slave_tdata ^ key_sel) & mask;
  assign s_bus = {slave_tlast, slave_tkeep, xdata};

  // Packet tracking: index, mode latch and counters advance per beat.
  always_comb begin
    idx_d    = idx_q;
    mode_d   = mode_q;
    in_pkt_d = in_pkt_q;
    beats_d  = beats_q;
    pkts_d   = pkts_q;
    if (accept) begin
      mode_d   = mode_cur;
      in_pkt_d = ~slave_tlast;
      beats_d  = beats_q + 1'b1;
      if (slave_tlast) begin
        pkts_d = pkts_q + 1'b1;
      end
      if (slave_tlast || idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Packet-tracking state registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      idx_q    <= '0;
      mode_q   <= BYPASS;
      in_pkt_q <= 1'b0;
      beats_q  <= '0;
      pkts_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      in_pkt_q <= in_pkt_d;
      beats_q  <= beats_d;
      pkts_q   <= pkts_d;
    end
  end

  // Key table; writes land at the edge, after this cycle's read.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        key_q[k] <= '0;
      end
    end else if (key_wr_en) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_wr_addr == IW'(k)) begin
          key_q[k] <= key_wr_data;
        end
      end
    end
  end

  axis_skid_buf #(
    .WIDTH(BW)
  ) u_skid (
    .clk_i     (aclk),
    .rst_i     (areset),
    .s_data_i  (s_bus),
    .s_valid_i (slave_tvalid),
    .s_ready_o (slave_tready),
    .m_data_o  (m_bus),
    .m_valid_o (master_tvalid),
    .m_ready_i (master_tready)
  );

  assign {master_tlast, master_tkeep, master_tdata} = m_bus;

  assign stat_beats = beats_q;
  assign stat_pkts  = pkts_q;

endmodule

// File: tb/tb_axis_xor_v2.sv
// tb_axis_xor_v2: scoreboard bench for the AXI-Stream XOR cipher.
// Driver pushes expected beats; a monitor pops them as they emit.
module tb_axis_xor_v2;

  localparam int W  = 128;
  localparam int NK = 4;
  localparam int CW = 32;
  localparam int KW = W / 8;

  typedef struct {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
    int            acc;
    logic          lat;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [W-1:0]  slave_tdata = '0;
  logic [KW-1:0] slave_tkeep = '0;
  logic          slave_tvalid = 1'b0;
  logic          slave_tready;
  logic          slave_tlast = 1'b0;
  logic [W-1:0]  master_tdata;
  logic [KW-1:0] master_tkeep;
  logic          master_tvalid;
  logic          master_tready = 1'b1;
  logic          master_tlast;
  logic [1:0]    cfg_mode = 2'd0;
  logic          key_wr_en = 1'b0;
  logic [1:0]    key_wr_addr = '0;
  logic [W-1:0]  key_wr_data = '0;
  logic [CW-1:0] stat_beats;
  logic [CW-1:0] stat_pkts;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   tr_mode = 0;
  int   ph = 0;
  logic stall_p = 1'b0;
  logic [W+KW:0] stall_v;

  axis_xor_v2 #(
    .WIDTH(W),
    .NUM_KEYS(NK),
    .CNT_W(CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .slave_tdata   (slave_tdata),
    .slave_tkeep   (slave_tkeep),
    .slave_tvalid  (slave_tvalid),
    .slave_tready  (slave_tready),
    .slave_tlast   (slave_tlast),
    .master_tdata  (master_tdata),
    .master_tkeep  (master_tkeep),
    .master_tvalid (master_tvalid),
    .master_tready (master_tready),
    .master_tlast  (master_tlast),
    .cfg_mode      (cfg_mode),
    .key_wr_en     (key_wr_en),
    .key_wr_addr   (key_wr_addr),
    .key_wr_data   (key_wr_data),
    .stat_beats    (stat_beats),
    .stat_pkts     (stat_pkts)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {KW{b}};
  endfunction

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Downstream ready: 0 = always, 1 = pattern 1,0,0, 2 = held low.
  always @(negedge aclk) begin
    case (tr_mode)
      0: master_tready = 1'b1;
      1: begin
        master_tready = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end
      default: master_tready = 1'b0;
    endcase
  end

  // Monitor: compare each emitted beat; check hold while stalled.
  always @(negedge aclk) begin
    #1;
    if (areset) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p)
        chk("stall_hold",
            {master_tvalid, master_tlast, master_tkeep, master_tdata},
            {1'b1, stall_v});
      if (master_tvalid && master_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got data %h expected none",
                   master_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {master_tlast, master_tkeep, master_tdata},
              {mon_e.l, mon_e.k, mon_e.d});
          if (mon_e.lat) chk("latency", cyc, mon_e.acc);
        end
      end
      stall_p = master_tvalid && !master_tready;
      stall_v = {master_tlast, master_tkeep, master_tdata};
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic [1:0] m,
                      input logic [W-1:0] ed, input logic lat,
                      input logic we = 1'b0, input logic [1:0] wa = 2'd0,
                      input logic [W-1:0] wd = '0);
    int   n;
    exp_t e;
    n = 0;
    @(negedge aclk);
    slave_tvalid = 1'b1;
    slave_tdata  = d;
    slave_tkeep  = k;
    slave_tlast  = l;
    cfg_mode     = m;
    key_wr_en    = we;
    key_wr_addr  = wa;
    key_wr_data  = wd;
    while (!slave_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!slave_tready) begin
      n_chk++;
      $display("FAIL send_timeout: got tready 0 expected 1");
      slave_tvalid = 1'b0;
      return;
    end
    e.d   = ed;
    e.k   = k;
    e.l   = l;
    e.acc = cyc + 1;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge aclk);
    slave_tvalid = 1'b0;
    key_wr_en    = 1'b0;
  endtask

  task automatic keywr(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge aclk);
    slave_tvalid = 1'b0;
    key_wr_en    = 1'b1;
    key_wr_addr  = a;
    key_wr_data  = d;
    @(negedge aclk);
    key_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      #2;
      n++;
    end while (exp_q.size() != 0 && n < 300);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] kb [4];
    kb[0] = 8'h11;
    kb[1] = 8'h22;
    kb[2] = 8'h33;
    kb[3] = 8'h44;

    repeat (3) @(negedge aclk);
    #2;
    chk("rst_tvalid", master_tvalid, 0);
    chk("rst_bus", {master_tlast, master_tkeep, master_tdata}, 0);
    chk("rst_tready", slave_tready, 0);
    chk("rst_stats", {stat_beats, stat_pkts}, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    #2;
    chk("tready_after_rst", slave_tready, 1);

    // 1: bypass, 3 beats
    send(128'h1, '1, 1'b0, 2'd0, 128'h1, 1'b1);
    send(128'h2, '1, 1'b0, 2'd0, 128'h2, 1'b1);
    send(128'h3, '1, 1'b1, 2'd0, 128'h3, 1'b1);
    idle();
    drain();
    chk("t1_beats", stat_beats, 3);
    chk("t1_pkts", stat_pkts, 1);

    // 2: rolling keys, 6-beat packet then restart
    for (int i = 0; i < 4; i++) keywr(2'(i), rep(kb[i]));
    for (int i = 0; i < 6; i++)
      send('0, '1, i == 5, 2'd2, rep(kb[i % 4]), 1'b1);
    send('0, '1, 1'b0, 2'd2, rep(8'h11), 1'b1);
    send('0, '1, 1'b1, 2'd2, rep(8'h22), 1'b1);
    idle();
    drain();
    chk("t2_beats", stat_beats, 11);
    chk("t2_pkts", stat_pkts, 3);

    // 3: back-pressure, 10 beats
    tr_mode = 1;
    for (int i = 0; i < 10; i++)
      send(W'(i), '1, i == 9, 2'd0, W'(i), 1'b0);
    idle();
    drain();
    tr_mode = 0;
    chk("t3_beats", stat_beats, 21);
    chk("t3_pkts", stat_pkts, 4);

    // 4: tkeep masking in static mode
    keywr(2'd0, rep(8'h0F));
    send('1, 16'h00FF, 1'b1, 2'd1, {64'h0, {8{8'hF0}}}, 1'b1);
    idle();
    drain();

    // 5: mid-packet mode change, same-cycle key write
    send('0, '1, 1'b0, 2'd2, rep(8'h0F), 1'b1);
    send('0, '1, 1'b0, 2'd2, rep(8'h22), 1'b1);
    send('0, '1, 1'b0, 2'd0, rep(8'h33), 1'b1,
         1'b1, 2'd2, rep(8'hAA));
    send('0, '1, 1'b1, 2'd0, rep(8'h44), 1'b1);
    send(128'h5, '1, 1'b1, 2'd0, 128'h5, 1'b1);
    send('0, '1, 1'b0, 2'd2, rep(8'h0F), 1'b1);
    send('0, '1, 1'b0, 2'd2, rep(8'h22), 1'b1);
    send('0, '1, 1'b1, 2'd2, rep(8'hAA), 1'b1);
    idle();
    drain();
    chk("t5_beats", stat_beats, 30);
    chk("t5_pkts", stat_pkts, 8);

    // 6: reset with a full skid buffer
    tr_mode = 2;
    send('0, '1, 1'b0, 2'd2, rep(8'h0F), 1'b0);
    send('0, '1, 1'b0, 2'd2, rep(8'h22), 1'b0);
    idle();
    #2;
    chk("t6_skid_full", {master_tvalid, slave_tready}, 2'b10);
    @(negedge aclk);
    areset = 1'b1;
    exp_q.delete();
    @(negedge aclk);
    #2;
    chk("t6_tvalid", master_tvalid, 0);
    chk("t6_stats", {stat_beats, stat_pkts}, 0);
    chk("t6_tready", slave_tready, 0);
    areset  = 1'b0;
    tr_mode = 0;
    @(negedge aclk);
    #2;
    chk("t6_tready_up", slave_tready, 1);
    keywr(2'd0, rep(8'h5A));
    keywr(2'd1, rep(8'h77));
    send('0, '1, 1'b0, 2'd2, rep(8'h5A), 1'b1);
    send('0, '1, 1'b1, 2'd2, rep(8'h77), 1'b1);
    idle();
    drain();
    chk("t6_beats", stat_beats, 2);
    chk("t6_pkts", stat_pkts, 1);

    repeat (3) @(negedge aclk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
